// File: rtl/simmem_resp_bank.sv
// Response bank: reserve a slot per request, fill it on response, release it, drain in per-ID order.
// Optional round-robin arbitration among IDs with `define SIMMEM_RESP_BANK_RR_EN.
module simmem_resp_bank #(
    parameter int DataWidth = 9,
    parameter int Capacity  = 32,
    parameter int IDWidth   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         rsv_valid_i,
    input  logic [IDWidth-1:0]           rsv_id_i,
    output logic                         rsv_ready_o,
    output logic [$clog2(Capacity)-1:0]  rsv_addr_o,
    input  logic                         in_valid_i,
    input  logic [IDWidth-1:0]           in_id_i,
    input  logic [DataWidth-1:0]         in_data_i,
    output logic                         in_ready_o,
    input  logic [Capacity-1:0]          release_en_i,
    output logic                         out_valid_o,
    output logic [DataWidth-1:0]         out_data_o,
    input  logic                         out_ready_i
);
    localparam int NumIds = 2**IDWidth;
    localparam int AddrW  = $clog2(Capacity);
    localparam int CntW   = $clog2(Capacity+1);

    logic [Capacity-1:0]  reserved_q, filled_q, released_q;
    logic [AddrW-1:0]     next_q [Capacity];
    logic [DataWidth-1:0] data_q [Capacity];

    logic [NumIds-1:0]    list_vld_q;
    logic [AddrW-1:0]     head_q [NumIds];
    logic [AddrW-1:0]     tail_q [NumIds];
    logic [AddrW-1:0]     fill_ptr_q [NumIds];
    logic [CntW-1:0]      unfilled_q [NumIds];

    logic [NumIds-1:0]    eligible, rsv_hit, in_hit, out_hit;
    logic [IDWidth-1:0]   grant_id;
    logic [AddrW-1:0]     free_addr, fill_addr, out_addr;
    logic                 rsv_fire, in_fire, out_fire;

    always_comb begin
        free_addr = '0;
        for (int k = Capacity-1; k >= 0; k--) begin
            if (!reserved_q[k]) free_addr = AddrW'(k);
        end
    end

    assign rsv_ready_o = ~&reserved_q;
    assign rsv_addr_o  = free_addr;
    assign in_ready_o  = (unfilled_q[in_id_i] != '0);
    assign fill_addr   = fill_ptr_q[in_id_i];

    // Only the list head may leave, and only once it is both filled and released.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumIds; i++) begin
            eligible[i] = list_vld_q[i] && filled_q[head_q[i]] && released_q[head_q[i]];
        end
    end

`ifdef SIMMEM_RESP_BANK_RR_EN
    logic [IDWidth-1:0] rr_ptr_q, hold_id_q, rr_pick, rr_idx;
    logic               hold_q, rr_found;

    always_comb begin
        rr_pick  = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int off = 0; off < NumIds; off++) begin
            rr_idx = rr_ptr_q + IDWidth'(off);
            if (!rr_found && eligible[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // A stalled grant is held so a newly eligible ID cannot displace it.
    assign grant_id = hold_q ? hold_id_q : rr_pick;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            hold_q    <= 1'b0;
            hold_id_q <= '0;
        end else begin
            if (out_fire) rr_ptr_q <= grant_id + IDWidth'(1);
            hold_q    <= out_valid_o && !out_ready_i;
            hold_id_q <= grant_id;
        end
    end
`else
    always_comb begin
        grant_id = '0;
        for (int i = NumIds-1; i >= 0; i--) begin
            if (eligible[i]) grant_id = IDWidth'(i);
        end
    end
`endif

    assign out_addr    = head_q[grant_id];
    assign out_valid_o = |eligible;
    assign out_data_o  = out_valid_o ? data_q[out_addr] : '0;

    assign rsv_fire = rsv_valid_i && rsv_ready_o;
    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    always_comb begin
        rsv_hit = '0;
        in_hit  = '0;
        out_hit = '0;
        if (rsv_fire) rsv_hit[rsv_id_i] = 1'b1;
        if (in_fire)  in_hit[in_id_i]   = 1'b1;
        if (out_fire) out_hit[grant_id] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved_q <= '0;
            filled_q   <= '0;
            released_q <= '0;
        end else begin
            for (int k = 0; k < Capacity; k++) begin
                if (release_en_i[k] && reserved_q[k]) released_q[k] <= 1'b1;
            end
            if (in_fire)  filled_q[fill_addr]    <= 1'b1;
            if (rsv_fire) reserved_q[free_addr]  <= 1'b1;
            if (out_fire) begin
                reserved_q[out_addr] <= 1'b0;
                filled_q[out_addr]   <= 1'b0;
                released_q[out_addr] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_fire) data_q[fill_addr] <= in_data_i;
        if (rsv_fire && list_vld_q[rsv_id_i]) next_q[tail_q[rsv_id_i]] <= free_addr;
    end

    // Per-ID list and fill pointer; reserve, fill and output may all hit one ID in a cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            list_vld_q <= '0;
            head_q     <= '{default: '0};
            tail_q     <= '{default: '0};
            fill_ptr_q <= '{default: '0};
            unfilled_q <= '{default: '0};
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                if (out_hit[i]) begin
                    if (head_q[i] == tail_q[i]) begin
                        if (rsv_hit[i]) begin
                            head_q[i] <= free_addr;
                            tail_q[i] <= free_addr;
                        end else begin
                            list_vld_q[i] <= 1'b0;
                        end
                    end else begin
                        head_q[i] <= next_q[head_q[i]];
                        if (rsv_hit[i]) tail_q[i] <= free_addr;
                    end
                end else if (rsv_hit[i]) begin
                    tail_q[i] <= free_addr;
                    if (!list_vld_q[i]) begin
                        head_q[i]     <= free_addr;
                        list_vld_q[i] <= 1'b1;
                    end
                end

                unfilled_q[i] <= unfilled_q[i] + CntW'(rsv_hit[i]) - CntW'(in_hit[i]);
                if (in_hit[i]) begin
                    if (unfilled_q[i] == CntW'(1)) begin
                        if (rsv_hit[i]) fill_ptr_q[i] <= free_addr;
                    end else begin
                        fill_ptr_q[i] <= next_q[fill_ptr_q[i]];
                    end
                end else if (rsv_hit[i] && unfilled_q[i] == '0) begin
                    fill_ptr_q[i] <= free_addr;
                end
            end
        end
    end
endmodule
